// File: rtl/tiger_hilo_ctrl.sv
// HI/LO register controller: MFHI/MFLO/MTHI/MTLO, single-cycle MULT/MULTU from an
// external multiplier, and DIV/DIVU launched onto an external fixed-latency divider.
module tiger_hilo_ctrl #(
  parameter int unsigned DIV_LATENCY = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        op_ready,
  output logic        stall_rq,
  output logic        mult_signed,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_product,
  output logic [31:0] div_numer,
  output logic [31:0] div_denom,
  output logic        div_signed,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remain,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        dbg_state_o
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_DIV_WAIT = 1'b1;

  localparam logic [2:0] OP_MFHI  = 3'd0;
  localparam logic [2:0] OP_MFLO  = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_MULTU = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  // Loading LATENCY-1 and committing on the zero edge gives exactly LATENCY wait cycles.
  localparam logic [3:0] CNT_INIT = 4'(DIV_LATENCY - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic [31:0] numer_q, numer_d;
  logic [31:0] denom_q, denom_d;
  logic        dsigned_q, dsigned_d;
  logic        accept;

  // Handshake: an op is taken on a rising edge where op_valid && op_ready; the
  // requester must hold op/rs/rt stable while stall_rq is high.
  always_comb begin
    op_ready    = (state_q == S_IDLE) && !flush;
    accept      = op_valid && op_ready;
    stall_rq    = op_valid && !op_ready;
    mult_signed = (op == OP_MULT);
    mult_a      = rs;
    mult_b      = rt;
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    numer_d        = numer_q;
    denom_d        = denom_q;
    dsigned_d      = dsigned_q;
    if (state_q == S_DIV_WAIT) begin
      if (flush) begin
        state_d = S_IDLE;
        count_d = 4'd0;
      end else if (count_q == 4'd0) begin
        lo_d    = div_quotient;
        hi_d    = div_remain;
        state_d = S_IDLE;
      end else begin
        count_d = count_q - 4'd1;
      end
    end else if (accept) begin
      case (op)
        OP_MFHI: begin
          result_d       = hi_q;
          result_valid_d = 1'b1;
        end
        OP_MFLO: begin
          result_d       = lo_q;
          result_valid_d = 1'b1;
        end
        OP_MTHI: hi_d = rs;
        OP_MTLO: lo_d = rs;
        OP_MULT, OP_MULTU: {hi_d, lo_d} = mult_product;
        OP_DIV, OP_DIVU: begin
          if (rt == 32'd0) begin
            hi_d = rs;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            numer_d   = rs;
            denom_d   = rt;
            dsigned_d = (op == OP_DIV);
            count_d   = CNT_INIT;
            state_d   = S_DIV_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      count_q        <= 4'd0;
      hi_q           <= 32'd0;
      lo_q           <= 32'd0;
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
      numer_q        <= 32'd0;
      denom_q        <= 32'd0;
      dsigned_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      numer_q        <= numer_d;
      denom_q        <= denom_d;
      dsigned_q      <= dsigned_d;
    end
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign div_numer    = numer_q;
  assign div_denom    = denom_q;
  assign div_signed   = dsigned_q;
  assign busy         = (state_q == S_DIV_WAIT);
  assign dbg_state_o  = state_q[0];

endmodule

// File: tb/tb_tiger_hilo_ctrl.sv
// Directed bench for tiger_hilo_ctrl with behavioural multiplier and a divider model
// whose outputs are only meaningful on the final cycle of the divide latency.
module tb_tiger_hilo_ctrl;

  localparam int L = 12;

  logic        clk = 1'b0;
  logic        reset, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        op_ready, stall_rq, mult_signed;
  logic [31:0] mult_a, mult_b;
  logic [63:0] mult_product;
  logic [31:0] div_numer, div_denom;
  logic        div_signed;
  logic [31:0] div_quotient, div_remain;
  logic [31:0] result;
  logic        result_valid;
  logic [31:0] hi, lo;
  logic        busy, dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  age = 5'd0;

  tiger_hilo_ctrl #(.DIV_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op(op),
    .rs(rs), .rt(rt), .op_ready(op_ready), .stall_rq(stall_rq),
    .mult_signed(mult_signed), .mult_a(mult_a), .mult_b(mult_b),
    .mult_product(mult_product), .div_numer(div_numer), .div_denom(div_denom),
    .div_signed(div_signed), .div_quotient(div_quotient), .div_remain(div_remain),
    .result(result), .result_valid(result_valid), .hi(hi), .lo(lo),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Multiplier model
  always_comb begin
    logic signed [63:0] sa, sb;
    sa = {{32{mult_a[31]}}, mult_a};
    sb = {{32{mult_b[31]}}, mult_b};
    if (mult_signed) mult_product = sa * sb;
    else             mult_product = {32'd0, mult_a} * {32'd0, mult_b};
  end

  // Divider model: garbage until the last wait cycle, so an early commit is visible.
  always @(posedge clk) age <= busy ? age + 5'd1 : 5'd0;

  always_comb begin
    div_quotient = 32'hBAD0_BAD0;
    div_remain   = 32'hBAD1_BAD1;
    if (age == 5'(L - 1) && div_denom != 32'd0) begin
      if (div_signed) begin
        if (div_numer == 32'h8000_0000 && div_denom == 32'hFFFF_FFFF) begin
          div_quotient = 32'h8000_0000;
          div_remain   = 32'd0;
        end else begin
          div_quotient = $signed(div_numer) / $signed(div_denom);
          div_remain   = $signed(div_numer) % $signed(div_denom);
        end
      end else begin
        div_quotient = div_numer / div_denom;
        div_remain   = div_numer % div_denom;
      end
    end
  end

  // Scoreboard
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_result(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check_eq({tag, "_data"}, {32'd0, result}, {32'd0, e});
    check_eq({tag, "_valid"}, {63'd0, result_valid}, 64'd1);
  endtask

  // Drivers
  task automatic set_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    rs       = a;
    rt       = b;
    #1;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    repeat (3) tick();
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    check_eq("rst_rvalid", {63'd0, result_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_state", {63'd0, dbg_state}, 64'd0);
    check_eq("rst_numer", {32'd0, div_numer}, 64'd0);
    check_eq("rst_denom", {32'd0, div_denom}, 64'd0);
    check_eq("rst_dsigned", {63'd0, div_signed}, 64'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_op_ready", {63'd0, op_ready}, 64'd1);

    // MULT / MULTU with -3 * 7
    set_op(3'd4, 32'hFFFF_FFFD, 32'd7);
    check_eq("mult_signed_hi", {63'd0, mult_signed}, 64'd1);
    check_eq("mult_a", {32'd0, mult_a}, 64'hFFFF_FFFD);
    tick(); idle();
    check_eq("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check_eq("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    set_op(3'd5, 32'hFFFF_FFFD, 32'd7);
    check_eq("multu_signed_lo", {63'd0, mult_signed}, 64'd0);
    tick(); idle();
    check_eq("multu_hi", {32'd0, hi}, 64'h6);
    check_eq("multu_lo", {32'd0, lo}, 64'hFFFF_FFEB);

    // MTHI then MFHI back-to-back
    set_op(3'd2, 32'hDEAD_BEEF, 32'd0);
    tick();
    set_op(3'd0, 32'd0, 32'd0);
    check_eq("mthi_mfhi_ready", {63'd0, op_ready}, 64'd1);
    check_eq("mthi_mfhi_stall", {63'd0, stall_rq}, 64'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    tick(); idle();
    check_result("mfhi_bb");
    tick();
    check_eq("mfhi_bb_one_cycle", {63'd0, result_valid}, 64'd0);

    // DIV -7 / 2 with MFLO held against it
    set_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_c0_ready", {63'd0, op_ready}, 64'd1);
    tick();
    set_op(3'd1, 32'd0, 32'd0);
    for (int c = 1; c <= L; c++) begin
      check_eq($sformatf("div_c%0d_ready", c), {63'd0, op_ready}, 64'd0);
      check_eq($sformatf("div_c%0d_stall", c), {63'd0, stall_rq}, 64'd1);
      check_eq($sformatf("div_c%0d_numer", c), {32'd0, div_numer}, 64'hFFFF_FFF9);
      tick();
    end
    check_eq("div_c13_ready", {63'd0, op_ready}, 64'd1);
    check_eq("div_c13_busy", {63'd0, busy}, 64'd0);
    check_eq("div_dsigned", {63'd0, div_signed}, 64'd1);
    exp_q.push_back(32'hFFFF_FFFD);
    tick();
    check_result("div_mflo");
    set_op(3'd0, 32'd0, 32'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    tick(); idle();
    check_result("div_mfhi");

    // DIVU by zero
    set_op(3'd7, 32'd100, 32'd0);
    tick(); idle();
    check_eq("divz_busy", {63'd0, busy}, 64'd0);
    check_eq("divz_hi", {32'd0, hi}, 64'd100);
    check_eq("divz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    tick();
    check_eq("divz_busy2", {63'd0, busy}, 64'd0);

    // DIVU 100 / 7: no early commit, exact latency
    set_op(3'd7, 32'd100, 32'd7);
    tick(); idle();
    check_eq("divu_busy_c1", {63'd0, busy}, 64'd1);
    check_eq("divu_dsigned", {63'd0, div_signed}, 64'd0);
    repeat (L - 1) tick();
    check_eq("divu_busy_c12", {63'd0, busy}, 64'd1);
    check_eq("divu_hi_c12", {32'd0, hi}, 64'd100);
    tick();
    check_eq("divu_busy_c13", {63'd0, busy}, 64'd0);
    check_eq("divu_hi", {32'd0, hi}, 64'd2);
    check_eq("divu_lo", {32'd0, lo}, 64'd14);

    // Signed overflow commits divider outputs untouched
    set_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(); idle();
    repeat (L) tick();
    check_eq("ovf_hi", {32'd0, hi}, 64'd0);
    check_eq("ovf_lo", {32'd0, lo}, 64'h8000_0000);

    // Flush mid-divide
    set_op(3'd2, 32'd5, 32'd0);
    tick();
    set_op(3'd3, 32'd9, 32'd0);
    tick();
    set_op(3'd6, 32'd1000, 32'd3);
    tick(); idle();
    repeat (4) tick();
    flush = 1'b1;
    #1;
    check_eq("flush_c5_busy", {63'd0, busy}, 64'd1);
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_c6_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_c6_ready", {63'd0, op_ready}, 64'd1);
    repeat (L) tick();
    check_eq("flush_hi", {32'd0, hi}, 64'd5);
    check_eq("flush_lo", {32'd0, lo}, 64'd9);
    set_op(3'd0, 32'd0, 32'd0);
    exp_q.push_back(32'd5);
    tick();
    check_result("flush_mfhi");
    set_op(3'd1, 32'd0, 32'd0);
    exp_q.push_back(32'd9);
    tick(); idle();
    check_result("flush_mflo");

    // Flush in IDLE drops the op
    flush = 1'b1;
    set_op(3'd2, 32'h1234_5678, 32'd0);
    check_eq("fidle_ready", {63'd0, op_ready}, 64'd0);
    check_eq("fidle_stall", {63'd0, stall_rq}, 64'd1);
    tick();
    set_op(3'd0, 32'd0, 32'd0);
    tick();
    flush = 1'b0; idle();
    check_eq("fidle_hi", {32'd0, hi}, 64'd5);
    check_eq("fidle_rvalid", {63'd0, result_valid}, 64'd0);

    // Reset during DIV_WAIT
    set_op(3'd6, 32'd50, 32'd5);
    tick(); idle();
    repeat (3) tick();
    check_eq("rdiv_busy_c4", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    check_eq("rdiv_hi", {32'd0, hi}, 64'd0);
    check_eq("rdiv_lo", {32'd0, lo}, 64'd0);
    check_eq("rdiv_result", {32'd0, result}, 64'd0);
    check_eq("rdiv_busy", {63'd0, busy}, 64'd0);
    check_eq("rdiv_numer", {32'd0, div_numer}, 64'd0);
    check_eq("rdiv_denom", {32'd0, div_denom}, 64'd0);
    reset = 1'b0;
    #1;
    check_eq("rdiv_ready", {63'd0, op_ready}, 64'd1);
    repeat (L + 3) tick();
    check_eq("rdiv_late_hi", {32'd0, hi}, 64'd0);
    check_eq("rdiv_late_lo", {32'd0, lo}, 64'd0);
    check_eq("rdiv_late_busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tiger_hilo_ctrl.md
TIGER_HILO_CTRL -- requirements
Module: tiger_hilo_ctrl

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 12, meaning clock cycles from divider operand presentation to valid quotient/remainder (legal range 2..15).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  in  1  pipeline clear; aborts the in-flight op, drops the same-cycle op.
REQ-005 SHALL have port op_valid  in  1  HI/LO operation presented.
REQ-006 SHALL have port op  in  3  0 MFHI, 1 MFLO, 2 MTHI, 3 MTLO, 4 MULT, 5 MULTU, 6 DIV, 7 DIVU.
REQ-007 SHALL have port rs, rt  in  32 each  operands.
REQ-008 SHALL have port op_ready  out  1  op accepted this cycle if op_valid high.
REQ-009 SHALL have port stall_rq  out  1  op_valid && !op_ready.
REQ-010 SHALL have port mult_signed  out  1  high for MULT; mult_a/mult_b out 32 each = rs/rt, combinational.
REQ-011 SHALL have port mult_product  in  64  same-cycle product of mult_a*mult_b.
REQ-012 SHALL have port div_numer, div_denom  out  32 each  latched divider operands; div_signed out 1.
REQ-013 SHALL have port div_quotient, div_remain  in  32 each  divider outputs.
REQ-014 SHALL have port result  out  32  MFHI/MFLO data; result_valid out 1.
REQ-015 SHALL have port hi, lo  out  32 each  architectural HI/LO; busy out 1 = state is DIV_WAIT.

Function
REQ-016 SHALL implement states IDLE and DIV_WAIT; op_ready = (state==IDLE) && !flush.
REQ-017 Accept = op_valid && op_ready; all effects below take place at the accepting edge unless stated.
REQ-018 MFHI/MFLO: result <= hi/lo value before that edge; result_valid high exactly one cycle after accept, else low.
REQ-019 MTHI: hi <= rs; MTLO: lo <= rs; other register unchanged.
REQ-020 MULT/MULTU: {hi,lo} <= mult_product; mult_signed = (op==4) combinationally; single cycle, state stays IDLE.
REQ-021 DIV/DIVU with rt != 0: div_numer <= rs, div_denom <= rt, div_signed <= (op==6), count <= DIV_LATENCY-1, state -> DIV_WAIT.
REQ-022 DIV_WAIT: count decrements each edge; at the edge where count==0 lo <= div_quotient, hi <= div_remain, state -> IDLE; DIV_WAIT lasts exactly DIV_LATENCY cycles.
REQ-023 div_numer/div_denom/div_signed SHALL hold stable throughout DIV_WAIT.
REQ-024 Divide by zero (rt==0, op 6 or 7): hi <= rs, lo <= 32'hFFFF_FFFF, state stays IDLE, divider not launched.
REQ-025 In DIV_WAIT all ops (including MFHI/MFLO, MT*, MULT*) SHALL be held off (op_ready low); no queueing.
REQ-026 flush in DIV_WAIT: state -> IDLE, count -> 0, hi/lo unchanged, quotient never committed.
REQ-027 flush in IDLE: op not accepted, no register change, result_valid low next cycle.
REQ-028 Signed division SHALL follow truncation toward zero, remainder sign of numerator (divider-defined); controller does no arithmetic on results.
REQ-029 Signed overflow (rs=32'h8000_0000, rt=32'hFFFF_FFFF) SHALL commit divider outputs unmodified.

Reset
REQ-030 reset SHALL force state IDLE, count 0, hi 0, lo 0, result 0, result_valid 0, div_numer 0, div_denom 0, div_signed 0.
REQ-031 reset SHALL take priority over flush and op acceptance, including mid-DIV_WAIT (division discarded).
REQ-032 op_ready SHALL be high in the first cycle after reset deasserts.

Verification
REQ-033 MULT rs=-3, rt=7 (product 64'hFFFF_FFFF_FFFF_FFEB) -> next cycle hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; MULTU same operands -> hi=32'h0000_0006, lo=32'hFFFF_FFEB.
REQ-034 DIV rs=-7, rt=2 at cycle 0, then MFLO held valid -> op_ready low cycles 1..12, stall_rq high, MFLO accepted cycle 13, result=32'hFFFF_FFFD one cycle later; MFHI -> 32'hFFFF_FFFF.
REQ-035 DIVU rs=100, rt=0 -> hi=100, lo=32'hFFFF_FFFF next cycle, busy never high.
REQ-036 DIV launched, flush at cycle 5 -> busy low cycle 6, hi/lo keep prior values (MTHI 5 / MTLO 9 earlier -> MFHI=5, MFLO=9).
REQ-037 reset asserted at cycle 4 of DIV_WAIT -> all outputs zero next cycle, op_ready high after deassert, no later commit.
REQ-038 MTHI 32'hDEAD_BEEF then MFHI back-to-back -> result=32'hDEAD_BEEF, result_valid one cycle, no stall.
